// File: rtl/bool_func_sweep_ctrl.sv
// Sweeps all eight {a,b,c} vectors into a 3-input boolean block, records y
// per vector into a truth table, and compares the table to a latched expected value.
module bool_func_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] truth_table,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] tt_q, tt_d;
  logic       pass_q, pass_d;
  logic [2:0] fail_q, fail_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          exp_d   = expected;
          tt_d    = 8'h00;
          pass_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        tt_d[idx_q] = y;
        if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end else begin
          // Verdict uses the table including the sample taken this cycle.
          state_d = S_DONE;
          pass_d  = (tt_d == exp_q);
          fail_d  = lowest_set(tt_d ^ exp_q);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
        cnt_d   = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    abc_d  = busy_d ? idx_d : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      exp_q   <= 8'h00;
      tt_q    <= 8'h00;
      pass_q  <= 1'b0;
      fail_q  <= 3'd0;
      abc_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a           = abc_q[2];
  assign b           = abc_q[1];
  assign c           = abc_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign truth_table = tt_q;
  assign fail_idx    = fail_q;

endmodule

// File: tb/tb_bool_func_sweep_ctrl.sv
// Bench for bool_func_sweep_ctrl: a SETTLE=2 instance for single sweeps and a
// SETTLE=1 instance for back-to-back sweeps with start held high.
module tb_bool_func_sweep_ctrl;
  localparam int S0 = 2;
  localparam int S1 = 1;
  localparam int L0 = 8 * (S0 + 1);
  localparam int L1 = 8 * (S1 + 1);
  localparam int P1 = L1 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start1;
  logic [7:0] expected, exp1, fn, fn1;
  logic       y, y1;
  logic       a, b, c, busy, done, pass;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [7:0] tt, tt1;
  logic [2:0] fidx, fidx1;

  // The function block under control is a lookup table indexed by {a,b,c}.
  assign y  = fn[{a, b, c}];
  assign y1 = fn1[{a1, b1, c1}];

  bool_func_sweep_ctrl #(.SETTLE(S0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .y(y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .truth_table(tt), .fail_idx(fidx)
  );

  bool_func_sweep_ctrl #(.SETTLE(S1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(exp1), .y(y1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tt1), .fail_idx(fidx1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] fn;
    logic [7:0] exp;
    logic [7:0] tt;
    logic       pass;
    logic [2:0] fidx;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [2:0] low_diff(input logic [7:0] x, input logic [7:0] z);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (x[i] != z[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] outs0();
    return {15'd0, a, b, c, busy, done, pass, tt, fidx};
  endfunction

  function automatic logic [31:0] outs1();
    return {15'd0, a1, b1, c1, busy1, done1, pass1, tt1, fidx1};
  endfunction

  // Called at a negedge with DUT idle; ends at the negedge of the IDLE cycle after DONE.
  task automatic run_sweep(input string nm, input logic [7:0] f, input logic [7:0] e,
                           input logic [7:0] w_tt, input logic w_pass, input logic [2:0] w_fi,
                           input bit disturb);
    int errs;
    errs     = 0;
    fn       = f;
    expected = e;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= L0 + 2; k++) begin
      @(negedge clk);
      if (k <= L0) begin
        if (busy !== 1'b1 || done !== 1'b0 || {a, b, c} !== 3'((k - 1) / (S0 + 1))) errs++;
      end else if (k == L0 + 1) begin
        if (busy !== 1'b0 || done !== 1'b1 || {a, b, c} !== 3'd0) errs++;
        chk($sformatf("%s truth_table", nm), 32'(tt), 32'(w_tt));
        chk($sformatf("%s pass", nm), 32'(pass), 32'(w_pass));
        chk($sformatf("%s fail_idx", nm), 32'(fidx), 32'(w_fi));
      end else begin
        if (busy !== 1'b0 || done !== 1'b0 || {a, b, c} !== 3'd0) errs++;
        if (tt !== w_tt || pass !== w_pass || fidx !== w_fi) errs++;
      end
      if (disturb) begin
        start = (k == 5 || k == 10);
        if (k == 7) expected = ~e;
      end
    end
    start = 1'b0;
    chk($sformatf("%s sequence_errors", nm), 32'(errs), 32'd0);
  endtask

  initial begin
    logic [7:0] rf, re;
    int errs, ndone;

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    expected = 8'h00; exp1 = 8'h00; fn = 8'h00; fn1 = 8'h00;

    tbl[0] = '{fn: 8'h96, exp: 8'h96, tt: 8'h96, pass: 1'b1, fidx: 3'd0};
    tbl[1] = '{fn: 8'hEA, exp: 8'hEB, tt: 8'hEA, pass: 1'b0, fidx: 3'd0};
    tbl[2] = '{fn: 8'h00, exp: 8'h80, tt: 8'h00, pass: 1'b0, fidx: 3'd7};
    tbl[3] = '{fn: 8'hFF, exp: 8'hFF, tt: 8'hFF, pass: 1'b1, fidx: 3'd0};
    tbl[4] = '{fn: 8'h0F, exp: 8'h1F, tt: 8'h0F, pass: 1'b0, fidx: 3'd4};
    tbl[5] = '{fn: 8'h5A, exp: 8'h3A, tt: 8'h5A, pass: 1'b0, fidx: 3'd5};

    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outs cyc%0d", i), outs0(), 32'd0);
      chk($sformatf("reset_outs1 cyc%0d", i), outs1(), 32'd0);
      if (i == 1) rst = 1'b0;
    end

    for (int i = 0; i < 6; i++)
      run_sweep($sformatf("vec%0d", i), tbl[i].fn, tbl[i].exp,
                tbl[i].tt, tbl[i].pass, tbl[i].fidx, 1'b0);

    run_sweep("ignored_start_parity", 8'h96, 8'h96, 8'h96, 1'b1, 3'd0, 1'b1);
    run_sweep("ignored_start_mismatch", 8'hEA, 8'hEB, 8'hEA, 1'b0, 3'd0, 1'b1);

    // Reset during vector 4, then a fresh start on the first cycle after reset.
    fn = 8'h96; expected = 8'h96; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    errs = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done !== 1'b0) errs++;
    end
    chk("midreset vector_before", 32'({a, b, c}), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset outs", outs0(), 32'd0);
    chk("midreset no_done", 32'(errs), 32'd0);
    rst = 1'b0;
    run_sweep("after_reset", 8'hC3, 8'hC3, 8'hC3, 1'b1, 3'd0, 1'b0);

    repeat (20) begin
      rf = 8'($urandom);
      re = ($urandom_range(0, 1) == 0) ? rf : 8'($urandom);
      run_sweep($sformatf("rand fn=%h exp=%h", rf, re), rf, re,
                rf, (rf == re), low_diff(rf, re), 1'b0);
    end

    // Start held high: each period is the busy sweep plus one DONE and one IDLE cycle.
    fn1 = 8'($urandom); exp1 = fn1; start1 = 1'b1;
    @(posedge clk);
    #1;
    errs = 0; ndone = 0;
    for (int k = 1; k <= 4 * P1; k++) begin
      int p;
      @(negedge clk);
      p = (k - 1) % P1;
      if (done1 === 1'b1) ndone++;
      if (p < L1) begin
        if (busy1 !== 1'b1 || done1 !== 1'b0 || {a1, b1, c1} !== 3'(p / (S1 + 1))) errs++;
      end else if (p == L1) begin
        if (busy1 !== 1'b0 || done1 !== 1'b1 || pass1 !== 1'b1 || tt1 !== fn1 || fidx1 !== 3'd0) errs++;
      end else begin
        if (busy1 !== 1'b0 || done1 !== 1'b0 || {a1, b1, c1} !== 3'd0) errs++;
      end
    end
    start1 = 1'b0;
    chk("back_to_back sequence_errors", 32'(errs), 32'd0);
    chk("back_to_back done_count", 32'(ndone), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
